// File: rtl/avl_reg_pkg.sv
// Shared definitions for the Avalon-MM register bank: control FSM states,
// CTRL word bit positions and default sizing.
package avl_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } ctrl_state_e;

    localparam int BUSY_BIT  = 0;
    localparam int DONE_BIT  = 1;
    localparam int START_BIT = 0;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_WORDS = 16;

endpackage

// File: rtl/avl_reg_bank_if.sv
// Avalon-MM slave bus bundle for the register bank.
interface avl_reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) ();
    logic                  avl_cs;
    logic                  avl_read;
    logic                  avl_write;
    logic [ADDR_W-1:0]     avl_addr;
    logic [DATA_W/8-1:0]   avl_byteenable;
    logic [DATA_W-1:0]     avl_writedata;
    logic [DATA_W-1:0]     avl_readdata;

    modport master (
        output avl_cs, avl_read, avl_write, avl_addr, avl_byteenable, avl_writedata,
        input  avl_readdata
    );

    modport slave (
        input  avl_cs, avl_read, avl_write, avl_addr, avl_byteenable, avl_writedata,
        output avl_readdata
    );
endinterface

// File: rtl/reg_word_be.sv
// One storage word with per-byte write lanes and a full-word load that
// takes priority over the byte-lane write.
module reg_word_be #(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              wr_en,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_en,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] word_q
);

    logic [DATA_W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (ld_en) begin
            word_d = ld_data;
        end else if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) word_d[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) word_q <= '0;
        else          word_q <= word_d;
    end

endmodule

// File: rtl/avl_reg_bank.sv
// Avalon-MM register bank: NUM_WORDS-1 byte-writable data words plus a CTRL
// word that launches an external engine and tracks busy/done.
module avl_reg_bank
    import avl_reg_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int NUM_WORDS = DEF_NUM_WORDS,
    localparam int ADDR_W    = $clog2(NUM_WORDS),
    localparam int BE_W      = DATA_W / 8
) (
    input  logic                              Clk,
    input  logic                              Reset_N,
    avl_reg_bank_if.slave                     avl,
    input  logic                              hw_load,
    input  logic [ADDR_W-1:0]                 hw_sel,
    input  logic [DATA_W-1:0]                 hw_data,
    output logic                              start,
    output logic                              busy,
    input  logic                              done,
    output logic [(NUM_WORDS-1)*DATA_W-1:0]   reg_flat
);

    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_WORDS - 1);

    ctrl_state_e       state_q, state_d;
    logic              done_flag_q, done_flag_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] ctrl_rd;
    logic [DATA_W-1:0] words [NUM_WORDS-1];

    logic avl_wr_ok;
    logic hw_ok;
    logic start_req;

    // Data-word writes are blocked while the engine owns the registers;
    // the hardware load port is never blocked.
    assign avl_wr_ok = avl.avl_cs && avl.avl_write && !busy && (avl.avl_addr < CTRL_ADDR);
    assign hw_ok     = hw_load && (hw_sel < CTRL_ADDR);
    assign start_req = avl.avl_cs && avl.avl_write && (avl.avl_addr == CTRL_ADDR)
                       && avl.avl_byteenable[0] && avl.avl_writedata[START_BIT];

    for (genvar k = 0; k < NUM_WORDS - 1; k++) begin : g_word
        reg_word_be #(.DATA_W(DATA_W)) u_word (
            .Clk     (Clk),
            .Reset_N (Reset_N),
            .wr_en   (avl_wr_ok && (avl.avl_addr == ADDR_W'(k))),
            .wr_be   (avl.avl_byteenable),
            .wr_data (avl.avl_writedata),
            .ld_en   (hw_ok && (hw_sel == ADDR_W'(k))),
            .ld_data (hw_data),
            .word_q  (words[k])
        );
        assign reg_flat[k*DATA_W +: DATA_W] = words[k];
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // START is only honoured from IDLE, so a START arriving with done is dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_req) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = done ? ST_IDLE : ST_RUN;
            ST_RUN:    if (done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start = (state_q == ST_LAUNCH);
        busy  = (state_q != ST_IDLE);
    end

    always_comb begin
        done_flag_d = done_flag_q;
        if (state_q == ST_IDLE && start_req) done_flag_d = 1'b0;
        else if (busy && done)               done_flag_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) done_flag_q <= 1'b0;
        else          done_flag_q <= done_flag_d;
    end

    always_comb begin
        ctrl_rd           = '0;
        ctrl_rd[BUSY_BIT] = busy;
        ctrl_rd[DONE_BIT] = done_flag_q;
    end

    // Read data comes from current register state, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = rdata_q;
        if (avl.avl_cs && avl.avl_read) begin
            rdata_d = '0;
            if (avl.avl_addr == CTRL_ADDR) rdata_d = ctrl_rd;
            for (int k = 0; k < NUM_WORDS - 1; k++) begin
                if (avl.avl_addr == ADDR_W'(k)) rdata_d = words[k];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign avl.avl_readdata = rdata_q;

endmodule

// File: tb/tb_avl_reg_bank.sv
// Directed bench for avl_reg_bank: default 32x16 instance plus a 64-bit,
// 5-word instance with out-of-range addresses.
module tb_avl_reg_bank;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset_N;

    avl_reg_bank_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
    logic         hw_load_a;
    logic [3:0]   hw_sel_a;
    logic [31:0]  hw_data_a;
    logic         start_a, busy_a, done_a;
    logic [479:0] flat_a;

    avl_reg_bank #(.DATA_W(32), .NUM_WORDS(16)) dut_a (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .avl      (bus_a),
        .hw_load  (hw_load_a),
        .hw_sel   (hw_sel_a),
        .hw_data  (hw_data_a),
        .start    (start_a),
        .busy     (busy_a),
        .done     (done_a),
        .reg_flat (flat_a)
    );

    avl_reg_bank_if #(.DATA_W(64), .ADDR_W(3)) bus_b ();
    logic         hw_load_b;
    logic [2:0]   hw_sel_b;
    logic [63:0]  hw_data_b;
    logic         start_b, busy_b, done_b;
    logic [255:0] flat_b;

    avl_reg_bank #(.DATA_W(64), .NUM_WORDS(5)) dut_b (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .avl      (bus_b),
        .hw_load  (hw_load_b),
        .hw_sel   (hw_sel_b),
        .hw_data  (hw_data_b),
        .start    (start_b),
        .busy     (busy_b),
        .done     (done_b),
        .reg_flat (flat_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rd_a;
    logic [63:0] rd_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_idle();
        bus_a.avl_cs = 0; bus_a.avl_read = 0; bus_a.avl_write = 0;
        bus_a.avl_addr = '0; bus_a.avl_byteenable = '0; bus_a.avl_writedata = '0;
        hw_load_a = 0; hw_sel_a = '0; hw_data_a = '0; done_a = 0;
    endtask

    task automatic b_idle();
        bus_b.avl_cs = 0; bus_b.avl_read = 0; bus_b.avl_write = 0;
        bus_b.avl_addr = '0; bus_b.avl_byteenable = '0; bus_b.avl_writedata = '0;
        hw_load_b = 0; hw_sel_b = '0; hw_data_b = '0; done_b = 0;
    endtask

    // Sets up a write on bus A for the next rising edge, without waiting.
    task automatic a_set_wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus_a.avl_cs = 1; bus_a.avl_write = 1;
        bus_a.avl_addr = addr; bus_a.avl_writedata = data; bus_a.avl_byteenable = be;
    endtask

    task automatic a_wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge Clk); a_set_wr(addr, data, be);
        @(negedge Clk); a_idle();
    endtask

    task automatic a_rd(input logic [3:0] addr, output logic [31:0] data);
        @(negedge Clk); bus_a.avl_cs = 1; bus_a.avl_read = 1; bus_a.avl_addr = addr;
        @(negedge Clk); a_idle(); data = bus_a.avl_readdata;
    endtask

    task automatic b_wr(input logic [2:0] addr, input logic [63:0] data, input logic [7:0] be);
        @(negedge Clk); bus_b.avl_cs = 1; bus_b.avl_write = 1;
        bus_b.avl_addr = addr; bus_b.avl_writedata = data; bus_b.avl_byteenable = be;
        @(negedge Clk); b_idle();
    endtask

    task automatic b_rd(input logic [2:0] addr, output logic [63:0] data);
        @(negedge Clk); bus_b.avl_cs = 1; bus_b.avl_read = 1; bus_b.avl_addr = addr;
        @(negedge Clk); b_idle(); data = bus_b.avl_readdata;
    endtask

    initial begin
        Reset_N = 0;
        a_idle(); b_idle();
        // Reset must beat a concurrent hardware load.
        hw_load_a = 1; hw_sel_a = 4'd1; hw_data_a = 32'h9999_9999;
        repeat (2) @(negedge Clk);
        check("rst_rdata", 64'(bus_a.avl_readdata), 64'h0);
        check("rst_start", 64'(start_a), 64'h0);
        check("rst_busy", 64'(busy_a), 64'h0);
        check("rst_flat", 64'(|flat_a), 64'h0);
        Reset_N = 1; a_idle();
        a_rd(4'd15, rd_a);
        check("rst_ctrl", 64'(rd_a), 64'h0);

        // Byte-lane write, registered read, read hold.
        a_wr(4'd2, 32'hAABB_CCDD, 4'b0101);
        a_rd(4'd2, rd_a);
        check("be_0101", 64'(rd_a), 64'h00BB_00DD);
        @(negedge Clk);
        check("rd_hold", 64'(bus_a.avl_readdata), 64'h00BB_00DD);

        // hw_load wins on the same word; different words both land.
        @(negedge Clk);
        a_set_wr(4'd3, 32'h1111_1111, 4'hF);
        hw_load_a = 1; hw_sel_a = 4'd3; hw_data_a = 32'h2222_2222;
        @(negedge Clk); a_idle();
        check("hw_wins_flat", 64'(flat_a[127:96]), 64'h2222_2222);
        @(negedge Clk);
        a_set_wr(4'd4, 32'h4444_4444, 4'hF);
        hw_load_a = 1; hw_sel_a = 4'd5; hw_data_a = 32'h5555_5555;
        @(negedge Clk); a_idle();
        check("both_w4", 64'(flat_a[159:128]), 64'h4444_4444);
        check("both_w5", 64'(flat_a[191:160]), 64'h5555_5555);
        a_rd(4'd3, rd_a);
        check("hw_wins_rd", 64'(rd_a), 64'h2222_2222);

        // Read and write to the same word in one cycle returns the old value.
        @(negedge Clk);
        a_set_wr(4'd2, 32'hFFFF_FFFF, 4'hF); bus_a.avl_read = 1;
        @(negedge Clk); a_idle();
        check("rdw_old", 64'(bus_a.avl_readdata), 64'h00BB_00DD);
        check("rdw_new", 64'(flat_a[95:64]), 64'hFFFF_FFFF);

        // hw_load aimed at CTRL does nothing.
        @(negedge Clk); hw_load_a = 1; hw_sel_a = 4'd15; hw_data_a = 32'h1;
        @(negedge Clk); a_idle();
        check("hw_ctrl_busy", 64'(busy_a), 64'h0);
        check("hw_ctrl_start", 64'(start_a), 64'h0);

        // START: one-cycle pulse, then busy.
        @(negedge Clk); a_set_wr(4'd15, 32'h1, 4'h1);
        @(negedge Clk); a_idle();
        check("start_c1", 64'(start_a), 64'h1);
        check("busy_c1", 64'(busy_a), 64'h1);
        @(negedge Clk);
        check("start_c2", 64'(start_a), 64'h0);
        check("busy_c2", 64'(busy_a), 64'h1);
        a_rd(4'd15, rd_a);
        check("ctrl_run", 64'(rd_a), 64'h1);
        a_wr(4'd0, 32'h1234_5678, 4'hF);
        check("wr_busy_blk", 64'(flat_a[31:0]), 64'h0);
        @(negedge Clk); hw_load_a = 1; hw_sel_a = 4'd1; hw_data_a = 32'hCAFE_F00D;
        @(negedge Clk); a_idle();
        check("hw_busy_ok", 64'(flat_a[63:32]), 64'hCAFE_F00D);
        @(negedge Clk); a_set_wr(4'd15, 32'h1, 4'h1);
        @(negedge Clk); a_idle();
        check("restart_nopulse", 64'(start_a), 64'h0);

        // done ends the run; done while idle is ignored.
        @(negedge Clk); done_a = 1;
        @(negedge Clk); a_idle();
        check("done_busy", 64'(busy_a), 64'h0);
        a_rd(4'd15, rd_a);
        check("ctrl_done", 64'(rd_a), 64'h2);
        @(negedge Clk); done_a = 1;
        @(negedge Clk); a_idle();
        a_rd(4'd15, rd_a);
        check("done_idle", 64'(rd_a), 64'h2);
        @(negedge Clk); a_set_wr(4'd15, 32'h1, 4'h1);
        @(negedge Clk); a_idle();
        check("start2_pulse", 64'(start_a), 64'h1);
        a_rd(4'd15, rd_a);
        check("ctrl_rerun", 64'(rd_a), 64'h1);

        // done in the LAUNCH cycle returns straight to IDLE.
        @(negedge Clk); done_a = 1;
        @(negedge Clk); a_idle();
        @(negedge Clk); a_set_wr(4'd15, 32'h1, 4'h1);
        @(negedge Clk); a_idle(); done_a = 1;
        check("launch_start", 64'(start_a), 64'h1);
        @(negedge Clk); a_idle();
        check("launch_done_busy", 64'(busy_a), 64'h0);
        check("launch_done_start", 64'(start_a), 64'h0);
        a_rd(4'd15, rd_a);
        check("launch_done_ctrl", 64'(rd_a), 64'h2);

        // done and START together while running: START dropped.
        @(negedge Clk); a_set_wr(4'd15, 32'h1, 4'h1);
        @(negedge Clk); a_idle();
        @(negedge Clk); a_set_wr(4'd15, 32'h1, 4'h1); done_a = 1;
        @(negedge Clk); a_idle();
        check("coll_busy", 64'(busy_a), 64'h0);
        @(negedge Clk);
        check("coll_start", 64'(start_a), 64'h0);
        a_rd(4'd15, rd_a);
        check("coll_ctrl", 64'(rd_a), 64'h2);

        // Reset while running, with loads, START and done all active.
        a_rd(4'd1, rd_a);
        check("pre_rst_rd", 64'(rd_a), 64'hCAFE_F00D);
        @(negedge Clk); a_set_wr(4'd15, 32'h1, 4'h1);
        @(negedge Clk); a_idle();
        @(negedge Clk);
        Reset_N = 0;
        a_set_wr(4'd15, 32'h1, 4'h1); done_a = 1;
        hw_load_a = 1; hw_sel_a = 4'd0; hw_data_a = 32'hDEAD_BEEF;
        @(negedge Clk);
        Reset_N = 1; a_idle();
        check("rrun_busy", 64'(busy_a), 64'h0);
        check("rrun_start", 64'(start_a), 64'h0);
        check("rrun_rdata", 64'(bus_a.avl_readdata), 64'h0);
        check("rrun_flat", 64'(|flat_a), 64'h0);
        @(negedge Clk);
        check("rrun_nopulse", 64'(start_a), 64'h0);
        a_rd(4'd15, rd_a);
        check("rrun_ctrl", 64'(rd_a), 64'h0);

        // 64-bit, 5-word instance: addresses 5..7 are out of range.
        b_wr(3'd0, 64'h0123_4567_89AB_CDEF, 8'hFF);
        b_rd(3'd0, rd_b);
        check("b_w0", rd_b, 64'h0123_4567_89AB_CDEF);
        b_wr(3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        check("b_oor_wr", 64'(|flat_b[255:64]), 64'h0);
        b_rd(3'd6, rd_b);
        check("b_oor_rd", rd_b, 64'h0);
        b_wr(3'd1, 64'hA5A5_A5A5_A5A5_A5A5, 8'h80);
        check("b_lane7", flat_b[127:64], 64'hA500_0000_0000_0000);
        @(negedge Clk); hw_load_b = 1; hw_sel_b = 3'd4; hw_data_b = 64'h1;
        @(negedge Clk); hw_sel_b = 3'd7; hw_data_b = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge Clk); b_idle();
        check("b_hw_ctrl", 64'(busy_b), 64'h0);
        check("b_hw_oor", 64'(|flat_b[255:128]), 64'h0);
        b_rd(3'd4, rd_b);
        check("b_ctrl", rd_b, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/avl_reg_bank.md
AVL_REG_BANK -- requirements
Module: avl_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter NUM_WORDS, default 16, total word slots including the control word (at least 2).
REQ-003 SHALL have derived parameter ADDR_W = clog2(NUM_WORDS) and BE_W = DATA_W/8.
REQ-004 Clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Reset_N  in  1  synchronous, active-low reset.
REQ-006 avl_cs, avl_read, avl_write  in  1 each  Avalon-MM slave strobes.
REQ-007 avl_addr  in  ADDR_W  word index.
REQ-008 avl_byteenable  in  BE_W  per-byte write lanes.
REQ-009 avl_writedata  in  DATA_W; avl_readdata  out  DATA_W.
REQ-010 hw_load  in  1, hw_sel  in  ADDR_W, hw_data  in  DATA_W  full-word hardware write port.
REQ-011 start  out  1  one-cycle start pulse; busy  out  1; done  in  1  completion strobe from the engine.
REQ-012 reg_flat  out  (NUM_WORDS-1)*DATA_W  packed data words; word k at bits [k*DATA_W +: DATA_W].

Function
REQ-013 Words 0..NUM_WORDS-2 SHALL be data words; word NUM_WORDS-1 SHALL be the control word (CTRL).
REQ-014 Avalon write (avl_cs & avl_write) to a data word SHALL update exactly the bytes whose byteenable bit is 1; any lane combination is legal; 0 lanes = no change.
REQ-015 Avalon writes to data words SHALL be ignored while busy=1.
REQ-016 hw_load SHALL write hw_data into data word hw_sel regardless of busy; hw_sel = CTRL or out of range SHALL be ignored.
REQ-017 Avalon write and hw_load to the same word in the same cycle: hw_load SHALL win entirely; different words: both SHALL take effect.
REQ-018 Reads: avl_readdata SHALL be registered, valid one cycle after avl_cs & avl_read, and hold its value otherwise.
REQ-019 Read in the same cycle as a write to the same word SHALL return the pre-write value.
REQ-020 CTRL read value SHALL be {zeros, done_flag (bit1), busy (bit0)}; out-of-range reads SHALL return 0; out-of-range writes ignored.
REQ-021 Write to CTRL with byteenable[0]=1 and writedata[0]=1 while busy=0 SHALL cause start=1 in the next cycle only, busy=1 and done_flag=0 from that cycle.
REQ-022 START write while busy=1 SHALL be ignored (no pulse, no state change); all other CTRL bits SHALL be write-ignored.
REQ-023 done=1 while busy=1 SHALL set busy=0 and done_flag=1 next cycle; done while busy=0 SHALL be ignored.
REQ-024 done and a START write in the same cycle while busy=1: done SHALL be taken, the START SHALL be dropped.
REQ-025 Control FSM SHALL have states IDLE (busy=0), LAUNCH (start=1, busy=1, one cycle), RUN (busy=1); IDLE->LAUNCH on START write; LAUNCH->RUN unconditionally unless done; LAUNCH/RUN->IDLE on done.
REQ-026 reg_flat SHALL reflect register contents directly (no added latency beyond the storing edge).

Reset
REQ-027 Reset_N=0 at a rising edge SHALL clear all data words, avl_readdata, start, busy and done_flag to 0 and force IDLE, overriding simultaneous writes, hw_load and done.
REQ-028 Reset during RUN SHALL abort without emitting start or setting done_flag.

Structure
REQ-029 Package avl_reg_pkg SHALL hold the FSM state enum, CTRL bit positions (BUSY_BIT=0, DONE_BIT=1, START_BIT=0) and default parameter values.
REQ-030 One sub-module, reg_word_be (DATA_W-wide byte-enabled word with a full-word override load), SHALL be instantiated per data word.

Verification
REQ-031 Reset, write addr 2 data 0xAABBCCDD be 0b0101 -> read addr 2 returns 0x00BB00DD one cycle after read.
REQ-032 Same cycle: Avalon write addr 3 0x11111111 be 0xF and hw_load sel 3 0x22222222 -> word 3 = 0x22222222, reg_flat[127:96]=0x22222222.
REQ-033 Write CTRL 0x1 -> start high exactly one cycle, CTRL reads 0x1; Avalon write addr 0 0x12345678 while busy -> word 0 unchanged.
REQ-034 done pulse during RUN -> CTRL reads 0x2 next cycle; second START write -> start pulse, CTRL reads 0x1.
REQ-035 Reset_N low during RUN with concurrent hw_load -> all words 0, CTRL reads 0x0, no start pulse.
REQ-036 Parameter sweep NUM_WORDS=5, DATA_W=64: write addr 6 ignored, read addr 6 returns 0, byte lane 7 write updates bits [63:56] only.
